// File: rtl/snake_move_ctrl_if.sv
// Bundles the button inputs, restart request and direction/step outputs of the snake move controller.
// Latency: none; plain signal bundle with no storage.
// Backpressure: none; the bus has no ready, outputs are levels plus a one-cycle strobe. Macro: SNAKE_SPEEDUP_EN adds `eat`.
interface snake_move_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       game_reset;
`ifdef SNAKE_SPEEDUP_EN
  logic       eat;
`endif
  logic [2:0] accion;
  logic       mover;
  logic       running;

  // Driver side: raw buttons and restart request in, direction/strobe observed.
  modport master (
`ifdef SNAKE_SPEEDUP_EN
    output eat,
`endif
    output btn_up, btn_down, btn_left, btn_right, game_reset,
    input  accion, mover, running
  );

  // Controller side.
  modport slave (
`ifdef SNAKE_SPEEDUP_EN
    input  eat,
`endif
    input  btn_up, btn_down, btn_left, btn_right, game_reset,
    output accion, mover, running
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// Turns four raw buttons into a committed direction code (accion) and a periodic one-cycle move strobe (mover).
// Latency: press seen 2 sync + DEBOUNCE_CYCLES cycles after the button settles; accion commits one cycle before mover.
// Backpressure: none; game_reset restarts to IDLE. Macro SNAKE_SPEEDUP_EN adds `eat` to shorten the move period.
module snake_move_ctrl #(
  parameter int MOVE_PERIOD     = 2500000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 32
`ifdef SNAKE_SPEEDUP_EN
  ,
  parameter int MIN_PERIOD      = 1000000,
  parameter int PERIOD_STEP     = 100000
`endif
) (
  input logic               uclk,
  input logic               rst,
  snake_move_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] MP      = CNT_W'(MOVE_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Button index order: 0=up, 1=down, 2=left, 3=right.
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [CNT_W-1:0] db_cnt [4];
  logic [3:0]       rise;

  logic [2:0]       code;
  logic [2:0]       opp;
  logic             accept;

  state_t           state;
  logic [2:0]       pending;
  logic [2:0]       committed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] commit_pt;

  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(PERIOD_STEP);

  logic [CNT_W-1:0] cur_period;
  logic [CNT_W-1:0] act_period;

  // Each eat pulse shortens the requested period, never below MIN_PERIOD.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      cur_period <= MP;
    end else if (bus.game_reset) begin
      cur_period <= MP;
    end else if (bus.eat) begin
      if (cur_period >= MINP + STEP) cur_period <= cur_period - STEP;
      else                           cur_period <= MINP;
    end
  end

  assign per = act_period;
`else
  assign per = MP;
`endif

  assign last_cnt  = per - ONE;
  assign commit_pt = per - TWO;

  // Two-flop synchroniser; only the hard reset clears it.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else if (bus.game_reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + ONE;
        end
      end
    end
  end

  // Press event: the debounced state is about to go 0->1 on this edge.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++)
      rise[i] = sync2[i] & ~deb[i] & (db_cnt[i] == DB_LAST);
  end

  // Pick one press (up > down > left > right) and drop reversals of the committed direction.
  always_comb begin
    code = 3'd0;
    if      (rise[0]) code = 3'd1;
    else if (rise[1]) code = 3'd2;
    else if (rise[2]) code = 3'd3;
    else if (rise[3]) code = 3'd4;
    case (committed)
      3'd1:    opp = 3'd2;
      3'd2:    opp = 3'd1;
      3'd3:    opp = 3'd4;
      3'd4:    opp = 3'd3;
      default: opp = 3'd0;
    endcase
    accept = (code != 3'd0) && (code != opp);
  end

  // Move FSM: wait for the first press, then commit and strobe once per period.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      committed   <= '0;
      cnt         <= '0;
      bus.accion  <= '0;
      bus.mover   <= 1'b0;
      bus.running <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      act_period  <= MP;
`endif
    end else if (bus.game_reset) begin
      state       <= IDLE;
      pending     <= '0;
      committed   <= '0;
      cnt         <= '0;
      bus.accion  <= '0;
      bus.mover   <= 1'b0;
      bus.running <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      act_period  <= MP;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt       <= '0;
          bus.mover <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
          act_period <= cur_period;
`endif
          if (accept) begin
            pending     <= code;
            committed   <= code;
            bus.accion  <= code;
            bus.running <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (accept) pending <= code;
          // Commit uses the pending value from before this edge; a press now waits a period.
          if (cnt == commit_pt) begin
            committed  <= pending;
            bus.accion <= pending;
          end
          if (cnt == last_cnt) begin
            cnt       <= '0;
            bus.mover <= 1'b1;
`ifdef SNAKE_SPEEDUP_EN
            act_period <= cur_period;
`endif
          end else begin
            cnt       <= cnt + ONE;
            bus.mover <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with DEBOUNCE_CYCLES=4 and MOVE_PERIOD=10 (20 when SNAKE_SPEEDUP_EN).
// Latency: outputs sampled 1 ns after each rising edge; inputs change at the same point.
// Backpressure: not applicable. Macro SNAKE_SPEEDUP_EN selects the speed-up sequence.
module tb_snake_move_ctrl;
`ifdef SNAKE_SPEEDUP_EN
  localparam int MP = 20;
`else
  localparam int MP = 10;
`endif

  logic uclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   moves;

  snake_move_ctrl_if bus();

  always #5 uclk = ~uclk;

  snake_move_ctrl #(
    .MOVE_PERIOD(MP),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(32)
`ifdef SNAKE_SPEEDUP_EN
    ,
    .MIN_PERIOD(12),
    .PERIOD_STEP(5)
`endif
  ) dut (
    .uclk(uclk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge uclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.game_reset = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    bus.eat        = 1'b0;
`endif
    #12;
    check("rst_accion", 32'(bus.accion), 0);
    check("rst_mover", 32'(bus.mover), 0);
    check("rst_running", 32'(bus.running), 0);
    step(1);
    rst = 1'b0;
    step(2);
    check("idle_running", 32'(bus.running), 0);

`ifdef SNAKE_SPEEDUP_EN
    // First press (right) sets T; eat pulses shorten subsequent periods.
    bus.btn_right = 1'b1;
    step(6);
    check("su_first_accion", 32'(bus.accion), 4);
    bus.btn_right = 1'b0;
    step(5);
    bus.eat = 1'b1;
    step(1);
    bus.eat = 1'b0;
    step(13);
    check("su_int20_before", 32'(bus.mover), 0);
    step(1);
    check("su_int20", 32'(bus.mover), 1);
    step(5);
    bus.eat = 1'b1;
    step(1);
    bus.eat = 1'b0;
    step(8);
    check("su_int15_before", 32'(bus.mover), 0);
    step(1);
    check("su_int15", 32'(bus.mover), 1);
    step(5);
    bus.eat = 1'b1;
    step(1);
    bus.eat = 1'b0;
    step(5);
    check("su_int12a_before", 32'(bus.mover), 0);
    step(1);
    check("su_int12a", 32'(bus.mover), 1);
    step(11);
    check("su_int12b_before", 32'(bus.mover), 0);
    step(1);
    check("su_int12b", 32'(bus.mover), 1);
    // game_reset restores the full period.
    step(1);
    bus.game_reset = 1'b1;
    step(1);
    bus.game_reset = 1'b0;
    check("su_greset_running", 32'(bus.running), 0);
    check("su_greset_accion", 32'(bus.accion), 0);
    bus.btn_right = 1'b1;
    step(6);
    check("su_restart_accion", 32'(bus.accion), 4);
    bus.btn_right = 1'b0;
    step(19);
    check("su_restored_before", 32'(bus.mover), 0);
    step(1);
    check("su_restored_20", 32'(bus.mover), 1);
`else
    // Right held 6 cycles from IDLE: accepted on the 6th edge (edge T).
    bus.btn_right = 1'b1;
    step(5);
    check("right_not_yet", 32'(bus.accion), 0);
    step(1);
    check("right_accion", 32'(bus.accion), 4);
    check("right_running", 32'(bus.running), 1);
    check("right_mover_low", 32'(bus.mover), 0);
    bus.btn_right = 1'b0;
    step(9);
    check("first_mover_early", 32'(bus.mover), 0);
    step(1);
    check("first_mover_T10", 32'(bus.mover), 1);
    step(1);
    check("first_mover_width", 32'(bus.mover), 0);
    step(9);
    check("second_mover_T20", 32'(bus.mover), 1);
    step(1);
    check("second_mover_width", 32'(bus.mover), 0);

    // T+21: up then left within one period; left is the reverse of committed right.
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_left = 1'b1;
    step(5);
    bus.btn_up = 1'b0;
    step(1);
    bus.btn_left = 1'b0;
    check("rev_before_commit", 32'(bus.accion), 4);
    step(1);
    check("rev_commit_up", 32'(bus.accion), 1);
    check("rev_commit_mover_low", 32'(bus.mover), 0);
    step(1);
    check("rev_mover_T30", 32'(bus.mover), 1);
    check("rev_accion_at_mover", 32'(bus.accion), 1);

    // T+34: left press (event T+40, committed at T+49).
    step(4);
    bus.btn_left = 1'b1;
    step(5);
    check("left_commit_T39", 32'(bus.accion), 1);
    step(1);
    check("left_mover_T40", 32'(bus.mover), 1);
    bus.btn_left = 1'b0;
    // T+46: down and left together (events T+52); down wins.
    step(6);
    bus.btn_down = 1'b1;
    bus.btn_left = 1'b1;
    step(3);
    check("left_commit_T49", 32'(bus.accion), 3);
    step(3);
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    check("prio_before_commit", 32'(bus.accion), 3);
    step(7);
    check("prio_down_T59", 32'(bus.accion), 2);
    step(1);
    check("prio_mover_T60", 32'(bus.mover), 1);

    // Asynchronous rst mid-cycle while running.
    step(2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_accion", 32'(bus.accion), 0);
    check("arst_mover", 32'(bus.mover), 0);
    check("arst_running", 32'(bus.running), 0);
    #1;
    rst = 1'b0;
    moves = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.mover) moves++;
    end
    check("arst_no_strobes", 32'(moves), 0);
    check("arst_still_idle", 32'(bus.running), 0);

    // Bouncing up from IDLE: 1-0-1-0 then stable high, one event at B10.
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_up = 1'b0;
    step(1);
    bus.btn_up = 1'b1;
    step(1);
    bus.btn_up = 1'b0;
    step(1);
    bus.btn_up = 1'b1;
    step(5);
    check("bounce_not_yet", 32'(bus.accion), 0);
    check("bounce_not_running", 32'(bus.running), 0);
    step(1);
    check("bounce_accion", 32'(bus.accion), 1);
    check("bounce_running", 32'(bus.running), 1);
    step(10);
    check("bounce_mover_B20", 32'(bus.mover), 1);

    // game_reset with up still held: back to IDLE, debounce restarts from 0.
    step(1);
    bus.game_reset = 1'b1;
    step(1);
    bus.game_reset = 1'b0;
    check("greset_accion", 32'(bus.accion), 0);
    check("greset_running", 32'(bus.running), 0);
    check("greset_mover", 32'(bus.mover), 0);
    step(3);
    check("greset_redeb_wait", 32'(bus.accion), 0);
    step(1);
    check("greset_redeb_accion", 32'(bus.accion), 1);
    bus.btn_up = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Upstream stage of the snake game logic block: turns four raw push-buttons into the `accion` direction code and the periodic `mover` step strobe that the game logic consumes.
- Synchronises and debounces the buttons, then holds a pending direction and rejects 180-degree reversals.
- Commits the pending direction once per move period, one cycle before `mover` rises, so `accion` is stable whenever `mover`=1.

Parameters:
- MOVE_PERIOD, 2500000, uclk cycles between move strobes (10 moves/s at 25 MHz); legal range >= 4.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button change is accepted; legal range >= 2.
- CNT_W, 32, width of the period and debounce counters.

Ports:
- uclk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- btn_up  in  1  raw button, active-high, asynchronous to uclk.
- btn_down  in  1  raw button.
- btn_left  in  1  raw button.
- btn_right  in  1  raw button.
- game_reset  in  1  synchronous restart request (the game logic's `reset` output: wall hit or rst).
- accion  out  3  direction code: 0=none, 1=up, 2=down, 3=left, 4=right.
- mover  out  1  one-cycle move strobe; low at all other times.
- running  out  1  high once the first direction has been accepted.

Behaviour:
- Reset (rst async, or game_reset sampled high):
  - accion=0, mover=0, running=0.
  - Pending and committed directions = 0; period counter = 0.
  - Debounced states = 0; synchroniser flops cleared on rst only.
- Input path, per button:
  - 2-flop synchroniser, then debounce counter.
  - Counter resets whenever the synchronised value equals the debounced state; otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
  - A press event is a 0->1 transition of the debounced state, one cycle wide.
- Press priority when several events occur in the same cycle: up > down > left > right. Only one event is considered.
- Reversal rule:
  - A press equal to the opposite of the committed direction is ignored (up/down, left/right).
  - The check is against `committed`, not `pending`, so two quick presses within one period cannot reverse the snake.
  - A press equal to the committed direction is accepted (no-op).
- FSM states:
  - IDLE:
    - Period counter held at 0; mover stays 0.
    - First accepted press: pending=committed=accion=code, running=1, go to RUN.
    - The first move strobe follows a full MOVE_PERIOD later.
  - RUN:
    - Period counter increments 0..MOVE_PERIOD-1, then wraps to 0.
    - Accepted press: pending <= code; the last accepted press in a period wins.
    - At count MOVE_PERIOD-2 (COMMIT cycle): committed <= pending, and accion updates on the following edge.
    - At count MOVE_PERIOD-1: mover=1 for exactly that cycle.
    - A press arriving in the COMMIT cycle goes to pending and is applied next period; the reversal check still uses the old committed value.
- game_reset has priority over every event in the same cycle and returns the FSM to IDLE.
- The game logic requires mover=0 between strobes to re-arm; guaranteed because the strobe is one cycle wide and MOVE_PERIOD >= 4.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- When defined:
  - Extra input `eat` (1 bit, one-cycle pulse).
  - Extra parameters MIN_PERIOD (default 1000000) and PERIOD_STEP (default 100000).
  - Internal `cur_period` register resets to MOVE_PERIOD on rst or game_reset.
  - Each `eat` pulse lowers cur_period by PERIOD_STEP, saturating at MIN_PERIOD.
  - The new period takes effect from the next counter wrap; the counter compares against cur_period instead of MOVE_PERIOD.
- When undefined: no `eat` port, and the period is fixed at MOVE_PERIOD.

Test Plan (MOVE_PERIOD=10, DEBOUNCE_CYCLES=4 unless stated):
- rst pulse mid-RUN, asynchronous to uclk -> accion=0, mover=0, running=0 immediately; no mover pulse for 50 cycles afterwards without a press.
- btn_right held 6 cycles from IDLE -> accion=4 and running=1 after sync (2) + debounce (4) cycles; first mover=1 exactly 10 cycles later; subsequent strobes every 10 cycles, each 1 cycle wide.
- Committed right (4); press up, then left within one period -> up accepted into pending, left rejected (checked against committed right); accion=1 before the next mover.
- btn_up bouncing 1-0-1-0 at 1-cycle intervals, then stable high -> exactly one press event, accion=1.
- btn_down and btn_left debounced in the same cycle while committed is left -> down wins by priority; accion=2 at the next commit.
- SNAKE_SPEEDUP_EN with MOVE_PERIOD=20, MIN_PERIOD=12, PERIOD_STEP=5 -> three `eat` pulses give strobe intervals 20, 15, 12, 12; game_reset restores 20.
